// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the fetch-queue entry type for the fetch stage
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
    // Entries carry the widest PC supported; narrower PCs are zero-extended on push
    localparam int PC_MAX_W = 64;
    typedef struct packed {
        logic [INSTR_W-1:0]  instr;
        logic [PC_MAX_W-1:0] pc_next;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two circular queue with single-cycle flush
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    // pointer and occupancy tracking; flush empties the queue in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // storage needs no reset: the head is only used while count says it is valid
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end
    assign pop_data = mem[rd_ptr];
    // overflow or underflow here means the issue credit logic upstream is broken
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (!(push && !pop && count == CW'(DEPTH)));
            assert (!(pop && count == '0));
        end
    end
endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: PC generation, instruction-memory issue and decode fetch queue
// Optional feature: define FETCH_QUEUE_PERF_EN to build the performance counters.
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              IMEM_AW  = 8,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                jump_taken,
    input  logic [PC_W-1:0]     pc_jump,
    input  logic                branch_taken,
    input  logic [PC_W-1:0]     pc_branch,
    output logic [IMEM_AW-1:0]  imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [INSTR_W-1:0]  id_instr,
    output logic [PC_W-1:0]     id_pc_next,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_bubble_cnt
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] issued_pc;
    logic [PC_W-1:0] issued_next;
    logic [PC_W-1:0] target;
    logic            inflight;
    logic            redirect;
    logic            issue;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign redirect    = jump_taken | branch_taken;
    assign target      = (jump_taken ? pc_jump : pc_branch) & ~PC_W'(3);
    assign id_valid    = count != '0;
    assign pop         = id_valid && id_ready && !redirect;
    assign push        = inflight && !redirect;
    // A slot freed by this cycle's pop is reusable, which keeps 1 instr/cycle at DEPTH=2
    assign issue       = !redirect &&
                         ({1'b0, count} + (CW+1)'(inflight) < (CW+1)'(DEPTH) + (CW+1)'(pop));
    assign imem_addr   = pc[IMEM_AW+1:2];
    assign issued_next = issued_pc + PC_W'(4);
    assign push_entry  = '{instr: imem_rdata, pc_next: PC_MAX_W'(issued_next)};
    assign id_instr    = id_valid ? head.instr : NOP_INSTR;
    assign id_pc_next  = id_valid ? PC_W'(head.pc_next) : '0;

    // PC and inflight tracking; a redirect drops any outstanding memory response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            issued_pc <= RESET_PC;
            inflight  <= 1'b0;
        end else if (redirect) begin
            pc       <= target;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                issued_pc <= pc;
                pc        <= pc + PC_W'(4);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .count     (count)
    );

`ifdef FETCH_QUEUE_PERF_EN
    // count accepted instructions and cycles where decode waited on an empty queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (id_ready && !id_valid) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`else
    assign perf_fetch_cnt  = '0;
    assign perf_bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: directed checks of issue, queueing, redirect, wrap and counters
module tb_fetch_queue_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_taken = 1'b0;
    logic        branch_taken = 1'b0;
    logic        id_ready = 1'b1;
    logic [31:0] pc_jump = '0;
    logic [31:0] pc_branch = '0;
    logic [31:0] imem_rdata;
    logic [7:0]  imem_addr;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_next;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fetch_queue_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .jump_taken      (jump_taken),
        .pc_jump         (pc_jump),
        .branch_taken    (branch_taken),
        .pc_branch       (pc_branch),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc_next      (id_pc_next),
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
    );

    function automatic logic [31:0] ins(input logic [7:0] a);
        return 32'hA500_0000 | {24'h0, a};
    endfunction

    always @(posedge clk) imem_rdata <= ins(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic hd(input string tag, input logic v, input logic [31:0] i, input logic [31:0] p);
        chk({tag, "_valid"}, 32'(id_valid), 32'(v));
        chk({tag, "_instr"}, id_instr, i);
        chk({tag, "_pcnext"}, id_pc_next, p);
    endtask

    initial begin
        tick();
        hd("rst", 1'b0, 0, 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_perf_fetch", perf_fetch_cnt, 0);
        chk("rst_perf_bubble", perf_bubble_cnt, 0);
        rst_n = 1'b1;
        tick();
        chk("e1_addr", 32'(imem_addr), 1);
        chk("e1_valid", 32'(id_valid), 0);
        tick();
        hd("e2", 1'b1, ins(8'h00), 32'd4);
        chk("e2_addr", 32'(imem_addr), 2);
        tick();
        hd("e3", 1'b1, ins(8'h01), 32'd8);
        chk("e3_addr", 32'(imem_addr), 3);
        tick();
        hd("e4", 1'b1, ins(8'h02), 32'd12);
        chk("e4_addr", 32'(imem_addr), 4);
        #3 rst_n = 1'b0;
        #1;
        hd("midrst", 1'b0, 0, 0);
        chk("midrst_addr", 32'(imem_addr), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("b1_addr", 32'(imem_addr), 1);
        id_ready = 1'b0;
        repeat (3) tick();
        chk("hold3_addr", 32'(imem_addr), 2);
        repeat (7) tick();
        hd("hold", 1'b1, ins(8'h00), 32'd4);
        chk("hold_addr", 32'(imem_addr), 2);
        id_ready = 1'b1;
        tick();
        hd("pop1", 1'b1, ins(8'h01), 32'd8);
        tick();
        hd("pop2", 1'b1, ins(8'h02), 32'd12);
        tick();
        hd("pop3", 1'b1, ins(8'h03), 32'd16);
        tick();
        hd("pop4", 1'b1, ins(8'h04), 32'd20);
        tick();
        hd("pop5", 1'b1, ins(8'h05), 32'd24);
        chk("pop5_addr", 32'(imem_addr), 7);
        id_ready = 1'b0;
        jump_taken = 1'b1;
        branch_taken = 1'b1;
        pc_jump = 32'h40;
        pc_branch = 32'h80;
        tick();
        jump_taken = 1'b0;
        branch_taken = 1'b0;
        chk("jmp_addr", 32'(imem_addr), 32'h10);
        hd("jmp_flush", 1'b0, 0, 0);
        id_ready = 1'b1;
        tick();
        hd("jmp_gap", 1'b0, 0, 0);
        chk("jmp_gap_addr", 32'(imem_addr), 32'h11);
        tick();
        hd("jmp_head", 1'b1, ins(8'h10), 32'h44);
        id_ready = 1'b0;
`ifdef FETCH_QUEUE_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, 5);
        chk("perf_bubble", perf_bubble_cnt, 3);
`else
        chk("perf_fetch_off", perf_fetch_cnt, 0);
        chk("perf_bubble_off", perf_bubble_cnt, 0);
`endif
        branch_taken = 1'b1;
        pc_branch = 32'h103;
        id_ready = 1'b1;
        tick();
        branch_taken = 1'b0;
        hd("br_flush", 1'b0, 0, 0);
        chk("br_addr", 32'(imem_addr), 32'h40);
        tick();
        hd("br_gap", 1'b0, 0, 0);
        tick();
        hd("br_head", 1'b1, ins(8'h40), 32'h104);
        tick();
        hd("br_next", 1'b1, ins(8'h41), 32'h108);
        jump_taken = 1'b1;
        pc_jump = 32'hFFFF_FFFC;
        tick();
        jump_taken = 1'b0;
        chk("wrap_addr_hi", 32'(imem_addr), 32'hFF);
        hd("wrap_flush", 1'b0, 0, 0);
        tick();
        chk("wrap_addr_lo", 32'(imem_addr), 0);
        tick();
        hd("wrap_head", 1'b1, ins(8'hFF), 32'h0);
        tick();
        hd("wrap_next", 1'b1, ins(8'h00), 32'h4);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
